sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 151 +++++++++++++++
 tb/tb_sipo_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - MSB-first serial-in parallel-out frame receiver
//
// Purpose:
//   Assembles WIDTH serial bits, qualified by sin_valid, into a parallel word.
//   A frame is opened by a frame_start pulse in IDLE. The first data bit lands
//   in pout[WIDTH-1]. pout_valid pulses for one cycle when a frame completes.
//   pout holds its value between frames.
//
// Optional feature:
//   SIPO_PARITY_EN - when defined, one even-parity bit follows the data bits.
//                    par_err reports (XOR of data bits) ^ parity bit.
//                    When not defined, par_err is tied to 0.
//
// Ports:
//   clk          in   sole clock, rising edge
//   clr          in   synchronous active-high reset
//   frame_start  in   opens a frame (honoured in IDLE only)
//   sin          in   serial data bit
//   sin_valid    in   qualifies sin
//   pout         out  [WIDTH-1:0] last completed word
//   pout_valid   out  one-cycle new-word strobe
//   busy         out  frame open (state not IDLE)
//   par_err      out  parity error, meaningful while pout_valid=1

module sipo_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             frame_start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             busy,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;
    logic [WIDTH-1:0] shifted;

    // Word as it looks after shifting in the current sin bit.
    assign shifted = {shreg_q[WIDTH-2:0], sin};

`ifdef SIPO_PARITY_EN
    logic par_err_q, par_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        pout_d       = pout_q;
        pout_valid_d = 1'b0;
`ifdef SIPO_PARITY_EN
        par_err_d    = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A sin_valid in the same cycle as frame_start is not a data bit.
                if (frame_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    shreg_d = shifted;
                    if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d      = IDLE;
                        pout_d       = shifted;
                        pout_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                if (sin_valid) begin
                    state_d      = IDLE;
                    pout_d       = shreg_q;
                    pout_valid_d = 1'b1;
                    // Even parity: data bits plus parity bit must XOR to 0.
                    par_err_d    = (^shreg_q) ^ sin;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
`ifdef SIPO_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pout_valid_q;
    assign busy       = (state_q != IDLE);
`ifdef SIPO_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - self-checking bench for sipo_rx

module tb_sipo_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         frame_start = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         busy;
    logic         par_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: last word the receiver should be presenting on pout.
    logic [W-1:0] exp_pout = '0;

    sipo_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .frame_start (frame_start),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .pout        (pout),
        .pout_valid  (pout_valid),
        .busy        (busy),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, observe outputs 1 time unit later.
    task automatic step(input logic fs, input logic v, input logic b, input logic c);
        clr         = c;
        frame_start = fs;
        sin_valid   = v;
        sin         = b;
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 = no gaps, 1 = idle cycle before every bit, 2 = random gaps.
    // restart_at: number of sampled bits after which a stray frame_start is pulsed (-1: none).
    task automatic send_frame(input logic [W-1:0] word, input int gap_mode,
                              input int restart_at, input logic pbit, input string tag);
        int   nbits;
        int   i;
        logic gap;
        logic restarted;
        logic exp_perr;
        logic b;
`ifdef SIPO_PARITY_EN
        nbits    = W + 1;
        exp_perr = (^word) ^ pbit;
`else
        nbits    = W;
        exp_perr = 1'b0;
`endif
        // Open the frame; a sin_valid in this cycle must not count as a bit.
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (busy !== 1'b1 || pout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s open: busy=%b pout_valid=%b, required busy=1 pout_valid=0",
                     tag, busy, pout_valid);
        end
        i = 0;
        restarted = 1'b0;
        while (i < nbits) begin
            if (i == restart_at && !restarted) begin
                restarted = 1'b1;
                step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                case (gap_mode)
                    1:       gap = (($urandom_range(0, 1) == 0) || 1'b1) ? 1'b1 : 1'b0;
                    2:       gap = ($urandom_range(0, 99) < 30);
                    default: gap = 1'b0;
                endcase
                if (gap) begin
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                    n_checks++;
                    if (busy !== 1'b1 || pout_valid !== 1'b0 || pout !== exp_pout) begin
                        n_fail++;
                        $display("FAIL %s gap bit%0d: busy=%b pv=%b pout=%h, required busy=1 pv=0 pout=%h",
                                 tag, i, busy, pout_valid, pout, exp_pout);
                    end
                end
                b = (i < W) ? word[W-1-i] : pbit;
                step(1'b0, 1'b1, b, 1'b0);
                i++;
            end
            if (i < nbits) begin
                n_checks++;
                if (busy !== 1'b1 || pout_valid !== 1'b0 || pout !== exp_pout) begin
                    n_fail++;
                    $display("FAIL %s mid bit%0d: busy=%b pv=%b pout=%h, required busy=1 pv=0 pout=%h",
                             tag, i, busy, pout_valid, pout, exp_pout);
                end
            end
        end
        exp_pout = word;
        n_checks++;
        if (pout_valid !== 1'b1 || pout !== word || busy !== 1'b0 || par_err !== exp_perr) begin
            n_fail++;
            $display("FAIL %s done: pv=%b pout=%h busy=%b par_err=%b, required pv=1 pout=%h busy=0 par_err=%b",
                     tag, pout_valid, pout, busy, par_err, word, exp_perr);
        end
    endtask

    task automatic idle_check(input string tag);
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        n_checks++;
        if (pout_valid !== 1'b0 || busy !== 1'b0 || pout !== exp_pout) begin
            n_fail++;
            $display("FAIL %s idle: pv=%b busy=%b pout=%h, required pv=0 busy=0 pout=%h",
                     tag, pout_valid, busy, pout, exp_pout);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (pout !== '0 || pout_valid !== 1'b0 || busy !== 1'b0 || par_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pout=%h pv=%b busy=%b par_err=%b, required all 0",
                     pout, pout_valid, busy, par_err);
        end
        // clr overrides a simultaneous frame_start.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_override: busy=%b, required 0", busy);
        end
        exp_pout = '0;
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 0, -1, 1'b0, "basic");
        idle_check("basic");
    endtask

    task automatic test_gapped();
        send_frame(8'hA5, 1, -1, 1'b0, "gapped");
        idle_check("gapped");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h3C, 0, -1, 1'b0, "b2b_first");
        send_frame(8'hC3, 0, -1, 1'b0, "b2b_second");
        idle_check("b2b");
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp_pout = '0;
        n_checks++;
        if (busy !== 1'b0 || pout !== '0 || pout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b pout=%h pv=%b, required busy=0 pout=00 pv=0",
                     busy, pout, pout_valid);
        end
        // Leftover bits after the reset must not complete anything.
        for (int k = 0; k < 6; k++) idle_check("mid_reset_tail");
        send_frame(8'h81, 0, -1, 1'b0, "after_reset");
        idle_check("after_reset");
    endtask

    task automatic test_restart();
        send_frame(8'hF0, 0, 4, 1'b0, "restart");
        idle_check("restart");
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        send_frame(8'hA5, 0, -1, 1'b0, "parity_ok");
        send_frame(8'hA5, 0, -1, 1'b1, "parity_err");
        idle_check("parity");
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] w;
        int           idles;
        for (int f = 0; f < 25; f++) begin
            w = W'($urandom);
            send_frame(w, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1,
                       1'($urandom_range(0, 1)), "random");
            idles = int'($urandom_range(0, 2));
            for (int k = 0; k < idles; k++) idle_check("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
        test_restart();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
